// File: rtl/instr_buffer_pkg.sv
// Shared types and sizing for the fetch-to-decode instruction buffer.
package instr_buffer_pkg;

    localparam int IB_WIDTH = 2;
    localparam int IB_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } FETCH_ENTRY;

endpackage

// File: rtl/instr_buffer.sv
// Circular instruction buffer between fetch and decode; fetch bundles visible 1 cycle after push.
// Stalls fetch when fewer than N slots are free (registered count only); decode pops a prefix.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int N          = IB_WIDTH,
    parameter int DEPTH      = IB_DEPTH,
    localparam int CNT_W     = $clog2(DEPTH) + 1,
    localparam int RDY_W     = $clog2(N + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 fetch_bundle_valid_i,
    input  FETCH_ENTRY [N-1:0]   fetch_entries_i,
    output logic                 ib_stall_o,
    input  logic                 flush_i,
    input  logic [RDY_W-1:0]     dispatch_ready_i,
    output logic [N-1:0]         dispatch_valid_o,
    output FETCH_ENTRY [N-1:0]   dispatch_entries_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 overflow_err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    FETCH_ENTRY         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;

    logic               w_push;
    logic [CNT_W-1:0]   w_rdy;
    logic [CNT_W-1:0]   w_pop_cnt;
    logic [CNT_W-1:0]   w_count_nxt;

    // No credit is given for same-cycle pops, so fetch sees a purely registered stall.
    assign ib_stall_o  = (CNT_W'(DEPTH) - r_count) < CNT_W'(N);
    assign w_push      = fetch_bundle_valid_i && !ib_stall_o && !flush_i;
    assign w_rdy       = CNT_W'(dispatch_ready_i);
    assign w_pop_cnt   = (w_rdy < r_count) ? w_rdy : r_count;
    assign w_count_nxt = r_count + (w_push ? CNT_W'(N) : '0) - w_pop_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (fetch_bundle_valid_i && ib_stall_o) begin
                r_ovf <= 1'b1;
            end
            if (flush_i) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= PTR_W'(r_head + w_pop_cnt);
                r_tail  <= w_push ? PTR_W'(r_tail + PTR_W'(N)) : r_tail;
                r_count <= w_count_nxt;
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            for (int i = 0; i < N; i++) begin
                r_mem[PTR_W'(r_tail + PTR_W'(i))] <= fetch_entries_i[i];
            end
        end
    end

    always_comb begin
        dispatch_valid_o   = '0;
        dispatch_entries_o = '0;
        for (int i = 0; i < N; i++) begin
            if (r_count > CNT_W'(i)) begin
                dispatch_valid_o[i]   = 1'b1;
                dispatch_entries_o[i] = r_mem[PTR_W'(r_head + PTR_W'(i))];
            end
        end
    end

    assign count_o        = r_count;
    assign overflow_err_o = r_ovf;

    a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
        r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_instr_buffer.sv
// Randomized scoreboard bench for instr_buffer (N=2, DEPTH=8) against a queue-based model.
module tb_instr_buffer;
    import instr_buffer_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 8;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               fetch_bundle_valid_i;
    FETCH_ENTRY [N-1:0] fetch_entries_i;
    logic               ib_stall_o;
    logic               flush_i;
    logic [1:0]         dispatch_ready_i;
    logic [N-1:0]       dispatch_valid_o;
    FETCH_ENTRY [N-1:0] dispatch_entries_o;
    logic [3:0]         count_o;
    logic               overflow_err_o;

    instr_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .fetch_bundle_valid_i (fetch_bundle_valid_i),
        .fetch_entries_i      (fetch_entries_i),
        .ib_stall_o           (ib_stall_o),
        .flush_i              (flush_i),
        .dispatch_ready_i     (dispatch_ready_i),
        .dispatch_valid_o     (dispatch_valid_o),
        .dispatch_entries_o   (dispatch_entries_o),
        .count_o              (count_o),
        .overflow_err_o       (overflow_err_o)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_pass   = 0;
    FETCH_ENTRY mq[$];      // model contents, oldest first
    FETCH_ENTRY exp_q[$];   // entries expected to be consumed by decode, in order
    bit         m_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One cycle: check visible state against the model, drive inputs, advance the model.
    task automatic step(input logic v, input logic [31:0] pc0, input logic fl, input int rdy);
        FETCH_ENTRY e0, e1;
        int sz, p;
        bit m_stall;
        @(negedge clock);
        sz = mq.size();
        chk("count", 64'(count_o), 64'(sz));
        chk("stall", 64'(ib_stall_o), 64'((DEPTH - sz) < N));
        chk("valid", 64'(dispatch_valid_o), (sz >= 2) ? 64'd3 : 64'(sz));
        chk("overflow", 64'(overflow_err_o), 64'(m_ovf));
        for (int i = 0; i < N; i++)
            if (i >= sz) chk("idle_lane_zero", dispatch_entries_o[i], 64'd0);
        e0.pc = pc0;        e0.inst = $urandom;
        e1.pc = pc0 + 32'd4; e1.inst = $urandom;
        fetch_bundle_valid_i = v;
        fetch_entries_i      = {e1, e0};
        flush_i              = fl;
        dispatch_ready_i     = 2'(rdy);
        m_stall = (DEPTH - sz) < N;
        if (v && m_stall) m_ovf = 1'b1;
        if (fl) begin
            mq.delete();
        end else begin
            p = (rdy < sz) ? rdy : sz;
            repeat (p) exp_q.push_back(mq.pop_front());
            if (v && !m_stall) begin
                mq.push_back(e0);
                mq.push_back(e1);
            end
        end
    endtask

    task automatic reset_mid_op();
        @(negedge clock);
        fetch_bundle_valid_i = 1'b0;
        flush_i              = 1'b0;
        dispatch_ready_i     = 2'd0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_stall", 64'(ib_stall_o), 64'd0);
        chk("rst_valid", 64'(dispatch_valid_o), 64'd0);
        chk("rst_entries", 64'(dispatch_entries_o[0]), 64'd0);
        chk("rst_overflow", 64'(overflow_err_o), 64'd0);
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Monitor: whatever decode consumes this cycle must match the scoreboard head.
    initial begin
        int nv, k;
        FETCH_ENTRY e;
        forever begin
            @(negedge clock);
            #3;
            if (reset_n && !flush_i) begin
                nv = (dispatch_valid_o == 2'b11) ? 2 : (dispatch_valid_o == 2'b01) ? 1 : 0;
                k  = (int'(dispatch_ready_i) < nv) ? int'(dispatch_ready_i) : nv;
                for (int i = 0; i < k; i++) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_underflow: lane %0d pc %h consumed, none expected", i,
                                 dispatch_entries_o[i].pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dispatch_entry", dispatch_entries_o[i], e);
                    end
                end
            end
        end
    end

    initial begin
        int pushes;
        logic [31:0] rpc;
        reset_n              = 1'b0;
        fetch_bundle_valid_i = 1'b0;
        fetch_entries_i      = '0;
        flush_i              = 1'b0;
        dispatch_ready_i     = 2'd0;
        #2;
        chk("init_count", 64'(count_o), 64'd0);
        chk("init_valid", 64'(dispatch_valid_o), 64'd0);
        chk("init_overflow", 64'(overflow_err_o), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Fill to full, then one push while stalled.
        for (int k = 0; k < 5; k++) step(1'b1, 32'(8 * k), 1'b0, 0);
        // Drain in order from full.
        repeat (5) step(1'b0, 32'd0, 1'b0, 2);

        // Partial pop alongside push, then a pop request larger than the count.
        step(1'b1, 32'h20, 1'b0, 0);
        step(1'b1, 32'h28, 1'b0, 0);
        step(1'b0, 32'd0,  1'b0, 1);
        step(1'b1, 32'h40, 1'b0, 1);
        step(1'b0, 32'd0,  1'b0, 2);
        step(1'b0, 32'd0,  1'b0, 1);
        step(1'b0, 32'd0,  1'b0, 2);
        step(1'b0, 32'd0,  1'b0, 0);

        // Flush with concurrent push and pop, then a fresh push.
        step(1'b1, 32'h50, 1'b0, 0);
        step(1'b1, 32'h58, 1'b0, 0);
        step(1'b1, 32'h60, 1'b0, 0);
        step(1'b1, 32'h68, 1'b1, 2);
        step(1'b1, 32'h70, 1'b0, 0);
        step(1'b0, 32'd0,  1'b0, 0);
        step(1'b0, 32'd0,  1'b0, 2);

        // Build count=5, then reset asynchronously mid-operation.
        for (int k = 0; k < 3; k++) step(1'b1, 32'h80 + 32'(8 * k), 1'b0, 0);
        step(1'b0, 32'd0, 1'b0, 1);
        reset_mid_op();

        // Wrap-around: 12 pushes honouring the stall, ready alternating 2/1.
        pushes = 0;
        for (int c = 0; c < 40 && pushes < 12; c++) begin
            if ((DEPTH - mq.size()) >= N) begin
                step(1'b1, 32'h100 + 32'(8 * pushes), 1'b0, (c % 2 == 0) ? 2 : 1);
                pushes++;
            end else begin
                step(1'b0, 32'd0, 1'b0, (c % 2 == 0) ? 2 : 1);
            end
        end
        repeat (6) step(1'b0, 32'd0, 1'b0, 2);

        // Random traffic, including pushes against stall and occasional flushes.
        rpc = 32'h1000;
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 2)));
            rpc += 32'd8;
        end
        repeat (6) step(1'b0, 32'd0, 1'b0, 2);
        @(negedge clock);
        #5;
        chk("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
